param_alu_sequencer: RTL and testbench
======================================

PARAM_ALU_SEQUENCER -- requirements
Module: param_alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, range 8..32: accumulator, register and result width.
REQ-002 SHALL have parameter DEPTH, default 4, one of 2/4/8: register-file entries; index width RW = clog2(DEPTH).
REQ-003 SHALL have port clk  in  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset: asynchronous, active-low.
REQ-005 SHALL have port ena  in  1  clock enable; when 0, all registers hold.
REQ-006 SHALL have port in_valid  in  1  instruction present.
REQ-007 SHALL have port in_instr  in  8  instruction: [7:6] opcode, [5:0] operand.
REQ-008 SHALL have port in_ready  out  1  instruction accepted when in_valid=1, in_ready=1 and ena=1 at a rising edge.
REQ-009 SHALL have port out_valid  out  1  result strobe for STORE.
REQ-010 SHALL have port out_data  out  WIDTH  last stored accumulator value.
REQ-011 SHALL have port acc_o  out  WIDTH  live accumulator.
REQ-012 SHALL have ports flag_z and flag_c  out  1 each  zero and carry/borrow flags.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port state_o  out  2  state code: IDLE=0, EXEC=1, WB=2, DONE=3.

Function
REQ-015 Opcodes SHALL be: 00 NOP; 01 LOADI, acc <= zero-extended [5:0]; 10 ALU, [5:3]=fff, [2:0]=register; 11 STORE, R[idx] <= acc.
REQ-016 The register index SHALL be in_instr[RW-1:0]; higher operand bits SHALL be ignored.
REQ-017 ALU fff SHALL select: 000 ADD, 001 SUB (acc-R), 010 AND, 011 OR, 100 XOR, 101 SHL1 acc, 110 SHR1 acc, 111 PASS (acc <= R); results truncated to WIDTH.
REQ-018 FSM SHALL be IDLE->EXEC on acceptance, then EXEC->WB->DONE->IDLE unconditionally, one state per enabled edge.
REQ-019 in_ready SHALL be 1 only in IDLE; acceptance SHALL latch in_instr into an internal instruction register.
REQ-020 EXEC SHALL compute the result; WB SHALL write acc, flags or R[idx].
REQ-021 out_valid SHALL be 1 exactly while in DONE after a STORE; out_data SHALL update at the WB edge and then hold.
REQ-022 Latency: accept at edge E0; out_valid high between edges E2 and E3; in_ready high again after E3; throughput one instruction per 4 enabled cycles.
REQ-023 flag_z SHALL be updated by LOADI and ALU ops.
REQ-024 flag_c SHALL take: ADD carry-out; SUB borrow; SHL bit shifted out of the MSB; SHR bit shifted out of the LSB.
REQ-025 flag_c SHALL be cleared by AND, OR, XOR, PASS and LOADI.
REQ-026 NOP and STORE SHALL leave both flags unchanged.
REQ-027 NOP SHALL traverse all states with no architectural update and no out_valid.
REQ-028 An ALU op whose source register equals the previous STORE target SHALL read the new value.
REQ-029 With ena=0 the FSM, all registers and all outputs SHALL hold, including out_valid during DONE.
REQ-030 in_valid SHALL be ignored outside IDLE.

Reset
REQ-031 On rst_n=0, immediately and independent of clk, the design SHALL enter state IDLE.
REQ-032 On rst_n=0, acc, all R[i], flags, out_data, out_valid and busy SHALL be 0, and in_ready SHALL be 1.
REQ-033 Reset asserted mid-instruction SHALL discard that instruction with no partial writes surviving.

Configuration
REQ-034 With PARAM_ALU_SEQ_MUL_EN defined, fff=111 SHALL be MUL: acc <= low WIDTH bits of acc*R, flag_c <= OR of the discarded high bits, flag_z updated.
REQ-035 Without PARAM_ALU_SEQ_MUL_EN, fff=111 SHALL be PASS and no multiplier SHALL be synthesised.

Verification (WIDTH=8, DEPTH=4)
REQ-036 Reset scenario: rst_n low 2 cycles -> all outputs 0, in_ready=1, state_o=0.
REQ-037 Program scenario: 41,C1,42,81,C0 -> out_valid pulses twice; out_data=01 then 03; acc_o=03.
REQ-038 Flags scenario: 41,C0,40,88 -> acc=FF, flag_c=1, flag_z=0; then 80 -> acc=00, flag_z=1, flag_c=1.
REQ-039 Enable scenario: ena=0 for 5 cycles while in EXEC of instruction 44 -> state_o stays 1; instruction then completes with acc=04.
REQ-040 Mid-op reset scenario: rst_n pulsed low during WB of C0 -> out_valid never asserted, R0=00, acc=00.
REQ-041 MUL scenario: 46,C1,47,B9 -> acc=2A with PARAM_ALU_SEQ_MUL_EN defined; acc=06 without it.

Source files
------------

// File: rtl/param_alu_sequencer.sv
// -----------------------------------------------------------------------------
// param_alu_sequencer
//
// Four-state instruction sequencer around an accumulator, a small register
// file and an ALU. Each accepted 8-bit instruction walks IDLE -> EXEC -> WB ->
// DONE -> IDLE, one state per enabled rising edge, so at most one instruction
// completes every four enabled cycles.
//
//   Instruction format: [7:6] opcode, [5:0] operand
//     00 NOP
//     01 LOADI  acc <= zero-extended operand
//     10 ALU    operand[5:3] = function, operand[RW-1:0] = register index
//     11 STORE  R[idx] <= acc, out_data <= acc, out_valid during DONE
//
//   ALU functions: 000 ADD, 001 SUB (acc-R), 010 AND, 011 OR, 100 XOR,
//                  101 SHL1 acc, 110 SHR1 acc, 111 PASS (acc <= R) or MUL.
//
// Optional feature macro: PARAM_ALU_SEQ_MUL_EN
//   Defined   -> function 111 is MUL: acc <= low WIDTH bits of acc*R,
//                flag_c <= OR of the discarded high bits.
//   Undefined -> function 111 is PASS and no multiplier is built.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; 0 holds every register and output
//   in_valid   in   instruction present
//   in_instr   in   8-bit instruction
//   in_ready   out  high only in IDLE
//   out_valid  out  high while in DONE after a STORE
//   out_data   out  last stored accumulator value
//   acc_o      out  live accumulator
//   flag_z     out  zero flag
//   flag_c     out  carry / borrow flag
//   busy       out  high in every state except IDLE
//   state_o    out  IDLE=0, EXEC=1, WB=2, DONE=3
// -----------------------------------------------------------------------------
module param_alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] acc_o,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy,
  output logic [1:0]       state_o
);

  localparam int unsigned RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OpNop   = 2'b00,
    OpLoadi = 2'b01,
    OpAlu   = 2'b10,
    OpStore = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    FnAdd  = 3'b000,
    FnSub  = 3'b001,
    FnAnd  = 3'b010,
    FnOr   = 3'b011,
    FnXor  = 3'b100,
    FnShl  = 3'b101,
    FnShr  = 3'b110,
    FnPass = 3'b111
  } fn_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [7:0]       instr_q, instr_d;
  logic [WIDTH-1:0] res_q, res_d;       // result computed in EXEC, committed in WB
  logic             res_c_q, res_c_d;   // carry that goes with res_q
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] rf_d [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode of the latched instruction
  // ---------------------------------------------------------------------------
  op_e              op;
  fn_e              fn;
  logic [RW-1:0]    idx;
  logic [5:0]       imm;
  logic [WIDTH-1:0] opnd;

  assign op   = op_e'(instr_q[7:6]);
  assign fn   = fn_e'(instr_q[5:3]);
  assign idx  = instr_q[RW-1:0];
  assign imm  = instr_q[5:0];
  assign opnd = rf_q[idx];

  // ---------------------------------------------------------------------------
  // Result datapath (used during EXEC)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   wide;

`ifdef PARAM_ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, opnd};
`endif

  always_comb begin
    alu_res = acc_q;
    alu_c   = 1'b0;
    wide    = '0;
    unique case (op)
      OpNop: begin
        alu_res = acc_q;
      end
      OpLoadi: begin
        alu_res = {{(WIDTH-6){1'b0}}, imm};
      end
      OpStore: begin
        alu_res = acc_q;
      end
      OpAlu: begin
        unique case (fn)
          FnAdd: begin
            wide    = {1'b0, acc_q} + {1'b0, opnd};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
          end
          FnSub: begin
            // Bit WIDTH of the widened difference is the borrow.
            wide    = {1'b0, acc_q} - {1'b0, opnd};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
          end
          FnAnd: alu_res = acc_q & opnd;
          FnOr:  alu_res = acc_q | opnd;
          FnXor: alu_res = acc_q ^ opnd;
          FnShl: begin
            alu_res = {acc_q[WIDTH-2:0], 1'b0};
            alu_c   = acc_q[WIDTH-1];
          end
          FnShr: begin
            alu_res = {1'b0, acc_q[WIDTH-1:1]};
            alu_c   = acc_q[0];
          end
          FnPass: begin
`ifdef PARAM_ALU_SEQ_MUL_EN
            alu_res = prod[WIDTH-1:0];
            alu_c   = |prod[2*WIDTH-1:WIDTH];
`else
            alu_res = opnd;
            alu_c   = 1'b0;
`endif
          end
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    res_d      = res_q;
    res_c_d    = res_c_q;
    acc_d      = acc_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    out_data_d = out_data_q;
    rf_d       = rf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = alu_res;
        res_c_d = alu_c;
        state_d = StWb;
      end
      StWb: begin
        // All architectural writes happen on the edge leaving WB, so a reset
        // any earlier leaves no trace of the instruction.
        unique case (op)
          OpNop: begin
          end
          OpLoadi, OpAlu: begin
            acc_d    = res_q;
            flag_z_d = (res_q == '0);
            flag_c_d = res_c_q;
          end
          OpStore: begin
            rf_d[idx]  = res_q;
            out_data_d = res_q;
          end
        endcase
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      res_q      <= '0;
      res_c_q    <= 1'b0;
      acc_q      <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf_q[i] <= '0;
      end
    end else if (ena) begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      res_q      <= res_d;
      res_c_q    <= res_c_d;
      acc_q      <= acc_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      out_data_q <= out_data_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, so they hold whenever ena is low.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone) && (op == OpStore);
  assign out_data  = out_data_q;
  assign acc_o     = acc_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_param_alu_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for param_alu_sequencer (WIDTH=8, DEPTH=4). The driver applies
// directed scenarios then random instructions with random clock-enable; every
// accepted instruction is run through a plain-arithmetic model and its
// expected end state is queued. A monitor pops one entry each time the DUT
// enters DONE and compares outputs.
// -----------------------------------------------------------------------------
module tb_param_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] acc_o;
  logic       flag_z;
  logic       flag_c;
  logic       busy;
  logic [1:0] state_o;

  param_alu_sequencer #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .acc_o    (acc_o),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .busy     (busy),
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] acc;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int m_acc;
  int m_r[4];
  bit m_z;
  bit m_c;
  bit rnd_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_z   = 0;
    m_c   = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    sb_q.delete();
  endtask

  task automatic model_apply(input logic [7:0] ins);
    exp_t e;
    int   r;
    int   t;
    e.v = 1'b0;
    e.d = 8'h00;
    r   = m_r[ins[1:0]];
    case (ins[7:6])
      2'b01: begin
        m_acc = int'(ins[5:0]);
        m_z   = (m_acc == 0);
        m_c   = 0;
      end
      2'b10: begin
        case (ins[5:3])
          3'd0: begin t = m_acc + r; m_c = (t > 255); m_acc = t % 256; end
          3'd1: begin m_c = (m_acc < r); m_acc = (m_acc - r + 256) % 256; end
          3'd2: begin m_acc = m_acc & r; m_c = 0; end
          3'd3: begin m_acc = m_acc | r; m_c = 0; end
          3'd4: begin m_acc = m_acc ^ r; m_c = 0; end
          3'd5: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
          3'd6: begin m_c = (m_acc % 2 == 1); m_acc = m_acc / 2; end
          default: begin
`ifdef PARAM_ALU_SEQ_MUL_EN
            t = m_acc * r; m_c = (t > 255); m_acc = t % 256;
`else
            m_acc = r; m_c = 0;
`endif
          end
        endcase
        m_z = (m_acc == 0);
      end
      2'b11: begin
        m_r[ins[1:0]] = m_acc;
        e.v = 1'b1;
        e.d = 8'(m_acc);
      end
      default: ;
    endcase
    e.acc = 8'(m_acc);
    e.z   = m_z;
    e.c   = m_c;
    sb_q.push_back(e);
  endtask

  function automatic logic pick_ena();
    return rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Waits for IDLE (keeping in_valid noisy while busy), then offers ins until
  // an enabled edge accepts it. Returns #1 after the accepting edge.
  task automatic send(input logic [7:0] ins);
    int guard;
    bit done;
    guard = 0;
    while (!in_ready && guard < 60) begin
      in_valid = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
      in_instr = 8'($urandom);
      ena      = pick_ena();
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready got 0 expected 1");
    end else begin
      done = 0;
      while (!done && guard < 120) begin
        in_valid = 1'b1;
        in_instr = ins;
        ena      = pick_ena();
        @(posedge clk);
        if (ena) begin
          done = 1;
          model_apply(ins);
        end
        #1;
        guard++;
      end
    end
    in_valid = 1'b0;
    ena      = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    ena      = 1'b1;
    while (!(in_ready && sb_q.size() == 0) && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_idle", {31'd0, in_ready && sb_q.size() == 0}, 32'd1);
  endtask

  // Monitor: compares on entry to DONE, and checks out_valid stays low elsewhere.
  initial begin : monitor
    logic [1:0] prev_st;
    exp_t       e;
    prev_st = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (state_o == 2'd3 && prev_st != 2'd3) begin
          if (out_valid) n_pulse++;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: DONE entered with no expected entry");
          end else begin
            e = sb_q.pop_front();
            check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
            if (e.v) check("out_data", {24'd0, out_data}, {24'd0, e.d});
            check("acc", {24'd0, acc_o}, {24'd0, e.acc});
            check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
            check("flag_c", {31'd0, flag_c}, {31'd0, e.c});
          end
        end
        if (state_o != 2'd3) check("ov_low", {31'd0, out_valid}, 32'd0);
      end
      prev_st = state_o;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"}, {24'd0, acc_o}, 32'd0);
    check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_state"}, {30'd0, state_o}, 32'd0);
    check({tag, "_flags"}, {30'd0, flag_z, flag_c}, 32'd0);
  endtask

  int base_pulse;

  initial begin : driver
    rnd_en   = 0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_instr = 8'h00;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Program: two stores, 01 then 03
    base_pulse = n_pulse;
    send(8'h41); send(8'hC1); send(8'h42); send(8'h81); send(8'hC0);
    drain();
    check("prog_pulses", n_pulse - base_pulse, 32'd2);
    check("prog_acc", {24'd0, acc_o}, 32'h03);
    check("prog_out_data", {24'd0, out_data}, 32'h03);

    // Flags: SUB borrow then ADD wrap to zero
    send(8'h41); send(8'hC0); send(8'h40); send(8'h88);
    drain();
    check("flags_sub_acc", {24'd0, acc_o}, 32'hFF);
    check("flags_sub_c", {31'd0, flag_c}, 32'd1);
    check("flags_sub_z", {31'd0, flag_z}, 32'd0);
    send(8'h80);
    drain();
    check("flags_add_acc", {24'd0, acc_o}, 32'h00);
    check("flags_add_z", {31'd0, flag_z}, 32'd1);
    check("flags_add_c", {31'd0, flag_c}, 32'd1);

    // Enable hold during EXEC
    send(8'h44);
    ena = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("ena_hold_state", {30'd0, state_o}, 32'd1);
    end
    ena = 1'b1;
    drain();
    check("ena_acc", {24'd0, acc_o}, 32'h04);

    // Reset during WB of a STORE
    send(8'h45);
    drain();
    send(8'hC0);
    @(posedge clk);
    #1;
    check("midrst_in_wb", {30'd0, state_o}, 32'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // R0 must be 0: 1 + R0 should give 1
    send(8'h41); send(8'h80);
    drain();
    check("midrst_r0", {24'd0, acc_o}, 32'h01);

    // Function 111 with acc=7, R1=6
    send(8'h46); send(8'hC1); send(8'h47); send(8'hB9);
    drain();
`ifdef PARAM_ALU_SEQ_MUL_EN
    check("fn111_acc", {24'd0, acc_o}, 32'h2A);
`else
    check("fn111_acc", {24'd0, acc_o}, 32'h06);
`endif

    // Random instructions with random enable and noise on in_valid while busy
    rnd_en = 1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom));
    end
    rnd_en = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
